riscv_regfile_mp: RTL

- Parametrised multi-port integer register file for the superscalar RISC-V core.
- Generalises the fixed 4-write/2-read, 32x32 file: configurable width, depth, write-port count and read-port count.
- Adds per-port write enables, a defined collision priority, a hardwired-zero register, optional write-to-read bypass, and a busy scoreboard used by issue logic for RAW stall detection.
- Sits between the decode/issue stage (read and allocate) and the writeback stage (write).

---
 rtl/riscv_regfile_mp_if.sv | 37 +++
 rtl/riscv_regfile_mp.sv | 114 +++++++++++
 2 files changed

// File: rtl/riscv_regfile_mp_if.sv
// riscv_regfile_mp_if
// Bundles the register-file traffic between issue/writeback and the file.
//   wr_en_i / wr_addr_i / wr_data_i : packed write ports (port k at [k*W +: W])
//   rd_addr_i / rd_data_o / rd_busy_o: packed read ports with RAW busy flags
//   alloc_valid_i / alloc_addr_i     : destination allocation from issue
//   flush_i                          : pipeline flush, clears the scoreboard
// master: issue/writeback side (drives requests). slave: the register file.
interface riscv_regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NWR   = 4,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]      wr_en_i;
    logic [NWR*AW-1:0]   wr_addr_i;
    logic [NWR*XLEN-1:0] wr_data_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic                alloc_valid_i;
    logic [AW-1:0]       alloc_addr_i;
    logic                flush_i;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        output alloc_valid_i, alloc_addr_i, flush_i,
        input  rd_data_o, rd_busy_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        input  alloc_valid_i, alloc_addr_i, flush_i,
        output rd_data_o, rd_busy_o
    );
endinterface

// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp
// Parametrised multi-port integer register file with a busy scoreboard.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset (clears data and busy bits)
//   bus   : riscv_regfile_mp_if.slave (write ports, read ports, alloc, flush)
// Reads are combinational. Colliding writes resolve to the highest-index
// port, and the same resolution feeds the optional write-to-read bypass.
module riscv_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NWR      = 4,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    riscv_regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs_r [NREGS];
    logic [NREGS-1:0]    busy_r;
    logic [NREGS-1:0]    wr_hit_s;
    logic [XLEN-1:0]     wr_val_s [NREGS];
    logic [NREGS-1:0]    busy_nxt_s;
    logic [NRD*XLEN-1:0] rd_data_s;
    logic [NRD-1:0]      rd_busy_s;

    // Per-register write decode; ascending port order lets the highest index win.
    always_comb begin
        wr_hit_s = {NREGS{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            wr_val_s[r] = {XLEN{1'b0}};
        end
        for (int k = 0; k < NWR; k++) begin
            if (bus.wr_en_i[k]) begin
                wr_hit_s[bus.wr_addr_i[k*AW +: AW]] = 1'b1;
                wr_val_s[bus.wr_addr_i[k*AW +: AW]] = bus.wr_data_i[k*XLEN +: XLEN];
            end else begin
            end
        end
        // Register 0 is hardwired: its writes are dropped entirely.
        if (ZERO_REG != 0) begin
            wr_hit_s[0] = 1'b0;
        end else begin
        end
    end

    // Register storage update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit_s[r]) begin
                    regs_r[r] <= wr_val_s[r];
                end
            end
        end
    end

    // Scoreboard next state: completing writes clear, a new alloc overrides.
    always_comb begin
        busy_nxt_s = busy_r & ~wr_hit_s;
        if (bus.alloc_valid_i &&
            !((ZERO_REG != 0) && (bus.alloc_addr_i == {AW{1'b0}}))) begin
            busy_nxt_s[bus.alloc_addr_i] = 1'b1;
        end else begin
        end
    end

    // Scoreboard register; flush clears everything including a same-cycle alloc.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r <= {NREGS{1'b0}};
        end else if (bus.flush_i) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Read ports: reset forces zero, then zero register, then bypass, then storage.
    always_comb begin
        rd_data_s = {(NRD*XLEN){1'b0}};
        rd_busy_s = {NRD{1'b0}};
        for (int j = 0; j < NRD; j++) begin
            logic [AW-1:0] ra;
            ra = bus.rd_addr_i[j*AW +: AW];
            if (rst_i) begin
                rd_data_s[j*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy_s[j]              = 1'b0;
            end else if ((ZERO_REG != 0) && (ra == {AW{1'b0}})) begin
                rd_data_s[j*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy_s[j]              = 1'b0;
            end else if ((BYPASS != 0) && wr_hit_s[ra]) begin
                // Forwarded data is the pending result, so the reader need not stall.
                rd_data_s[j*XLEN +: XLEN] = wr_val_s[ra];
                rd_busy_s[j]              = 1'b0;
            end else begin
                rd_data_s[j*XLEN +: XLEN] = regs_r[ra];
                rd_busy_s[j]              = busy_r[ra];
            end
        end
    end

    assign bus.rd_data_o = rd_data_s;
    assign bus.rd_busy_o = rd_busy_s;

endmodule
